// File: rtl/ctl_duck_multi.sv
// ctl_duck_multi
//   Multi-channel duck controller. Owns N_DUCKS independent ducks: spawns
//   them from the shared random generator, moves them once per frame with
//   edge bouncing, lets them escape off the top after REFLECT bounces and
//   resolves mouse shots against every flying duck.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   new_frame    one-cycle pulse per video frame
//   start        begin a round (honoured only while every duck is idle)
//   rnd_dir      spawn horizontal direction, 1 = right
//   rnd_start_x  spawn x
//   rnd_v_spd    spawn vertical speed (0 is promoted to 1)
//   mouse_x/y    cursor position
//   mouse_left   left button level, already synchronous to clk
//   duck_x/y     packed positions, duck i at [11*i +: 11]
//   duck_show    duck i is drawn
//   duck_hit     duck i uses the hit sprite
//   hit_cnt      ducks shot this round (saturating)
//   esc_cnt      ducks escaped this round (saturating)
//   round_done   one-cycle pulse when every duck has finished
//
// state  | meaning
// IDLE   | waiting for start
// WAIT   | spawn delay, timer counts frames down
// FLY    | flying and bouncing, counting bounces
// ESC    | escaping, top wall no longer reflects
// FRZ    | shot, hanging in place, timer counts frames down
// FALL   | shot, dropping to the ground
// DONE   | finished, waiting for the rest of the round
module ctl_duck_multi #(
  parameter int N_DUCKS   = 2,
  parameter int REFLECT   = 15,
  parameter int H_SPEED   = 10,
  parameter int SCREEN_W  = 1024,
  parameter int GROUND_Y  = 600,
  parameter int DUCK_W    = 64,
  parameter int DUCK_H    = 64,
  parameter int FALL_SPD  = 8,
  parameter int FREEZE_FR = 30,
  parameter int SPAWN_GAP = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_frame,
  input  logic                   start,
  input  logic                   rnd_dir,
  input  logic [9:0]             rnd_start_x,
  input  logic [4:0]             rnd_v_spd,
  input  logic [11:0]            mouse_x,
  input  logic [11:0]            mouse_y,
  input  logic                   mouse_left,
  output logic [11*N_DUCKS-1:0]  duck_x,
  output logic [11*N_DUCKS-1:0]  duck_y,
  output logic [N_DUCKS-1:0]     duck_show,
  output logic [N_DUCKS-1:0]     duck_hit,
  output logic [3:0]             hit_cnt,
  output logic [3:0]             esc_cnt,
  output logic                   round_done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_FLY  = 3'd2;
  localparam logic [2:0] S_ESC  = 3'd3;
  localparam logic [2:0] S_FRZ  = 3'd4;
  localparam logic [2:0] S_FALL = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [11:0] X_MAX    = 12'(SCREEN_W - DUCK_W);
  localparam logic [11:0] Y_GND    = 12'(GROUND_Y);
  localparam logic [11:0] H_STEP   = 12'(H_SPEED);
  localparam logic [11:0] F_STEP   = 12'(FALL_SPD);
  localparam logic [11:0] W_BOX    = 12'(DUCK_W);
  localparam logic [11:0] H_BOX    = 12'(DUCK_H);
  localparam logic [11:0] FRZ_LOAD = 12'(FREEZE_FR - 1);
  localparam logic [3:0]  REFL     = 4'(REFLECT);

  logic [2:0]  st_q    [N_DUCKS];
  logic [2:0]  st_d    [N_DUCKS];
  logic [11:0] x_q     [N_DUCKS];
  logic [11:0] x_d     [N_DUCKS];
  logic [11:0] y_q     [N_DUCKS];
  logic [11:0] y_d     [N_DUCKS];
  logic [11:0] tmr_q   [N_DUCKS];
  logic [11:0] tmr_d   [N_DUCKS];
  logic [4:0]  spd_q   [N_DUCKS];
  logic [4:0]  spd_d   [N_DUCKS];
  logic [3:0]  bnc_q   [N_DUCKS];
  logic [3:0]  bnc_d   [N_DUCKS];
  logic [4:0]  bsum    [N_DUCKS];
  logic [N_DUCKS-1:0] right_q, right_d, up_q, up_d;
  logic [N_DUCKS-1:0] hb, vb, esc_ev, in_box, hit_sel;

  logic        mouse_prev, shot, taken, all_idle, all_done;
  logic [11:0] spawn_x;
  logic [4:0]  spawn_spd;
  logic [3:0]  esc_sum;
  logic [4:0]  esc_tot;

  assign shot      = mouse_left & ~mouse_prev;
  assign spawn_x   = ({2'b00, rnd_start_x} > X_MAX) ? X_MAX : {2'b00, rnd_start_x};
  assign spawn_spd = (rnd_v_spd == 5'd0) ? 5'd1 : rnd_v_spd;

  always_comb begin
    all_idle = 1'b1;
    all_done = 1'b1;
    for (int i = 0; i < N_DUCKS; i++) begin
      if (st_q[i] != S_IDLE) all_idle = 1'b0;
      if (st_q[i] != S_DONE) all_done = 1'b0;
    end
  end

  // Shot resolution uses the registered (pre-move) positions; the lowest
  // index wins so one click can only ever take out a single duck.
  always_comb begin
    hit_sel = '0;
    taken   = 1'b0;
    for (int i = 0; i < N_DUCKS; i++) begin
      in_box[i] = ((st_q[i] == S_FLY) || (st_q[i] == S_ESC)) &&
                  (mouse_x >= x_q[i]) && (mouse_x < x_q[i] + W_BOX) &&
                  (mouse_y >= y_q[i]) && (mouse_y < y_q[i] + H_BOX);
      if (shot && in_box[i] && !taken) begin
        hit_sel[i] = 1'b1;
        taken      = 1'b1;
      end
    end
  end

  always_comb begin
    esc_sum = '0;
    for (int i = 0; i < N_DUCKS; i++) begin
      st_d[i]    = st_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      tmr_d[i]   = tmr_q[i];
      spd_d[i]   = spd_q[i];
      bnc_d[i]   = bnc_q[i];
      right_d[i] = right_q[i];
      up_d[i]    = up_q[i];
      hb[i]      = 1'b0;
      vb[i]      = 1'b0;
      esc_ev[i]  = 1'b0;
      bsum[i]    = '0;
      if (all_done) begin
        st_d[i] = S_IDLE;
      end else if (hit_sel[i]) begin
        st_d[i]  = S_FRZ;
        tmr_d[i] = FRZ_LOAD;
      end else begin
        case (st_q[i])
          S_IDLE: if (start && all_idle) begin
            st_d[i]  = S_WAIT;
            tmr_d[i] = 12'(i * SPAWN_GAP);
          end
          S_WAIT: if (new_frame) begin
            if (tmr_q[i] == 12'd0) begin
              st_d[i]    = S_FLY;
              x_d[i]     = spawn_x;
              y_d[i]     = Y_GND;
              right_d[i] = rnd_dir;
              up_d[i]    = 1'b1;
              spd_d[i]   = spawn_spd;
              bnc_d[i]   = '0;
            end else begin
              tmr_d[i] = tmr_q[i] - 12'd1;
            end
          end
          S_FLY, S_ESC: if (new_frame) begin
            if (right_q[i]) begin
              if (x_q[i] + H_STEP > X_MAX) begin
                x_d[i] = X_MAX;  right_d[i] = 1'b0;  hb[i] = 1'b1;
              end else begin
                x_d[i] = x_q[i] + H_STEP;
              end
            end else if (x_q[i] < H_STEP) begin
              x_d[i] = '0;  right_d[i] = 1'b1;  hb[i] = 1'b1;
            end else begin
              x_d[i] = x_q[i] - H_STEP;
            end
            if (st_q[i] == S_FLY) begin
              if (up_q[i]) begin
                if (y_q[i] < {7'd0, spd_q[i]}) begin
                  y_d[i] = '0;  up_d[i] = 1'b0;  vb[i] = 1'b1;
                end else begin
                  y_d[i] = y_q[i] - {7'd0, spd_q[i]};
                end
              end else if (y_q[i] + {7'd0, spd_q[i]} > Y_GND) begin
                y_d[i] = Y_GND;  up_d[i] = 1'b1;  vb[i] = 1'b1;
              end else begin
                y_d[i] = y_q[i] + {7'd0, spd_q[i]};
              end
              bsum[i]  = {1'b0, bnc_q[i]} + {4'd0, hb[i]} + {4'd0, vb[i]};
              bnc_d[i] = (bsum[i] > 5'd15) ? 4'hF : bsum[i][3:0];
              // Escape is decided on the post-move count, so the frame that
              // delivers the last bounce already switches to climbing out.
              if (bnc_d[i] >= REFL) begin
                st_d[i] = S_ESC;
                up_d[i] = 1'b1;
              end
            end else if (y_q[i] < {7'd0, spd_q[i]}) begin
              st_d[i]   = S_DONE;
              esc_ev[i] = 1'b1;
            end else begin
              y_d[i] = y_q[i] - {7'd0, spd_q[i]};
            end
          end
          S_FRZ: if (new_frame) begin
            if (tmr_q[i] == 12'd0) st_d[i] = S_FALL;
            else                   tmr_d[i] = tmr_q[i] - 12'd1;
          end
          S_FALL: if (new_frame) begin
            if (y_q[i] + F_STEP >= Y_GND) begin
              y_d[i]  = Y_GND;
              st_d[i] = S_DONE;
            end else begin
              y_d[i] = y_q[i] + F_STEP;
            end
          end
          default: ;
        endcase
      end
      esc_sum = esc_sum + {3'd0, esc_ev[i]};
    end
  end

  assign esc_tot = {1'b0, esc_cnt} + {1'b0, esc_sum};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_DUCKS; i++) begin
        st_q[i]  <= S_IDLE;
        x_q[i]   <= '0;
        y_q[i]   <= Y_GND;
        tmr_q[i] <= '0;
        spd_q[i] <= '0;
        bnc_q[i] <= '0;
      end
      right_q    <= '0;
      up_q       <= '0;
      mouse_prev <= 1'b0;
      hit_cnt    <= '0;
      esc_cnt    <= '0;
      round_done <= 1'b0;
    end else begin
      for (int i = 0; i < N_DUCKS; i++) begin
        st_q[i]  <= st_d[i];
        x_q[i]   <= x_d[i];
        y_q[i]   <= y_d[i];
        tmr_q[i] <= tmr_d[i];
        spd_q[i] <= spd_d[i];
        bnc_q[i] <= bnc_d[i];
      end
      right_q    <= right_d;
      up_q       <= up_d;
      mouse_prev <= mouse_left;
      round_done <= all_done;
      if (start && all_idle) begin
        hit_cnt <= '0;
        esc_cnt <= '0;
      end else begin
        if ((|hit_sel) && (hit_cnt != 4'hF)) hit_cnt <= hit_cnt + 4'd1;
        esc_cnt <= (esc_tot > 5'd15) ? 4'hF : esc_tot[3:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_DUCKS; i++) begin
      duck_x[11*i +: 11] = x_q[i][10:0];
      duck_y[11*i +: 11] = y_q[i][10:0];
      duck_show[i] = (st_q[i] == S_FLY) || (st_q[i] == S_ESC) ||
                     (st_q[i] == S_FRZ) || (st_q[i] == S_FALL);
      duck_hit[i]  = (st_q[i] == S_FRZ) || (st_q[i] == S_FALL);
    end
  end

endmodule

// File: tb/tb_ctl_duck_multi.sv
// tb_ctl_duck_multi
//   Drives ctl_duck_multi with directed and random frame/start/mouse traffic
//   and compares every cycle against a frame-level model of the duck game.
module tb_ctl_duck_multi;

  localparam int N    = 3;
  localparam int REFL = 2;
  localparam int XMAX = 1024 - 64;
  localparam int GND  = 600;
  localparam int HSP  = 10;
  localparam int BOX  = 64;
  localparam int FSP  = 8;
  localparam int FRZ  = 30;
  localparam int GAP  = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             new_frame, start, rnd_dir, mouse_left;
  logic [9:0]       rnd_start_x;
  logic [4:0]       rnd_v_spd;
  logic [11:0]      mouse_x, mouse_y;
  logic [11*N-1:0]  duck_x, duck_y;
  logic [N-1:0]     duck_show, duck_hit;
  logic [3:0]       hit_cnt, esc_cnt;
  logic             round_done;

  always #5 clk = ~clk;

  ctl_duck_multi #(.N_DUCKS(N), .REFLECT(REFL)) dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .start(start),
    .rnd_dir(rnd_dir), .rnd_start_x(rnd_start_x), .rnd_v_spd(rnd_v_spd),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_left(mouse_left),
    .duck_x(duck_x), .duck_y(duck_y), .duck_show(duck_show),
    .duck_hit(duck_hit), .hit_cnt(hit_cnt), .esc_cnt(esc_cnt),
    .round_done(round_done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: one record per duck, advanced by game rules.
  typedef enum int {P_IDLE, P_WAIT, P_FLY, P_ESC, P_FRZ, P_FALL, P_DONE} phase_t;
  phase_t ph [N];
  int dx [N], dy [N], spd [N], bnc [N], cnt [N];
  bit right [N], up [N];
  int e_hit, e_esc;
  bit e_done, m_prev;

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ph[i] = P_IDLE; dx[i] = 0; dy[i] = GND; spd[i] = 0; bnc[i] = 0; cnt[i] = 0;
      right[i] = 0; up[i] = 0;
    end
    e_hit = 0; e_esc = 0; e_done = 0; m_prev = 0;
  endtask

  task automatic model_step(input bit nf, input bit st, input bit rdir, input int rx,
                            input int rv, input int mx, input int my, input bit ml);
    bit shot, every_done, every_idle;
    int hit, b;
    shot = ml && !m_prev;
    m_prev = ml;
    every_done = 1; every_idle = 1;
    for (int i = 0; i < N; i++) begin
      if (ph[i] != P_DONE) every_done = 0;
      if (ph[i] != P_IDLE) every_idle = 0;
    end
    e_done = every_done;
    if (every_done) begin
      for (int i = 0; i < N; i++) ph[i] = P_IDLE;
      return;
    end
    hit = -1;
    if (shot)
      for (int i = 0; i < N; i++)
        if (hit < 0 && (ph[i] == P_FLY || ph[i] == P_ESC) &&
            mx >= dx[i] && mx < dx[i] + BOX && my >= dy[i] && my < dy[i] + BOX)
          hit = i;
    for (int i = 0; i < N; i++) begin
      if (i == hit) begin
        ph[i] = P_FRZ; cnt[i] = FRZ; e_hit = sat15(e_hit + 1);
        continue;
      end
      if (!nf) continue;
      case (ph[i])
        P_WAIT: if (cnt[i] == 0) begin
            dx[i] = (rx > XMAX) ? XMAX : rx; dy[i] = GND; right[i] = rdir; up[i] = 1;
            spd[i] = (rv < 1) ? 1 : rv; bnc[i] = 0; ph[i] = P_FLY;
          end else cnt[i]--;
        P_FLY, P_ESC: begin
          b = 0;
          if (right[i]) begin
            if (dx[i] + HSP > XMAX) begin dx[i] = XMAX; right[i] = 0; b++; end
            else dx[i] += HSP;
          end else if (dx[i] < HSP) begin dx[i] = 0; right[i] = 1; b++; end
          else dx[i] -= HSP;
          if (ph[i] == P_FLY) begin
            if (up[i]) begin
              if (dy[i] < spd[i]) begin dy[i] = 0; up[i] = 0; b++; end
              else dy[i] -= spd[i];
            end else if (dy[i] + spd[i] > GND) begin dy[i] = GND; up[i] = 1; b++; end
            else dy[i] += spd[i];
            bnc[i] = sat15(bnc[i] + b);
            if (bnc[i] >= REFL) begin ph[i] = P_ESC; up[i] = 1; end
          end else if (dy[i] < spd[i]) begin
            ph[i] = P_DONE; e_esc = sat15(e_esc + 1);
          end else dy[i] -= spd[i];
        end
        P_FRZ: begin cnt[i]--; if (cnt[i] == 0) ph[i] = P_FALL; end
        P_FALL: begin
          dy[i] += FSP;
          if (dy[i] >= GND) begin dy[i] = GND; ph[i] = P_DONE; end
        end
        default: ;
      endcase
    end
    if (st && every_idle) begin
      e_hit = 0; e_esc = 0;
      for (int i = 0; i < N; i++) begin ph[i] = P_WAIT; cnt[i] = i * GAP; end
    end
  endtask

  task automatic compare(input bit all_pos);
    bit es, eh;
    check("round_done", int'(round_done), int'(e_done));
    check("hit_cnt", int'(hit_cnt), e_hit);
    check("esc_cnt", int'(esc_cnt), e_esc);
    for (int i = 0; i < N; i++) begin
      es = ph[i] inside {P_FLY, P_ESC, P_FRZ, P_FALL};
      eh = ph[i] inside {P_FRZ, P_FALL};
      check($sformatf("show%0d", i), int'(duck_show[i]), int'(es));
      check($sformatf("hit%0d", i), int'(duck_hit[i]), int'(eh));
      if (es || all_pos) begin
        check($sformatf("x%0d", i), int'(duck_x[11*i +: 11]), dx[i]);
        check($sformatf("y%0d", i), int'(duck_y[11*i +: 11]), dy[i]);
      end
    end
  endtask

  task automatic step();
    model_step(new_frame, start, rnd_dir, int'(rnd_start_x), int'(rnd_v_spd),
               int'(mouse_x), int'(mouse_y), mouse_left);
    @(posedge clk); #1;
    compare(1'b0);
    cyc++;
  endtask

  task automatic pick_mouse(input bit aim);
    int cand[$];
    int j, tx, ty;
    if (aim)
      for (int i = 0; i < N; i++)
        if (ph[i] == P_FLY || ph[i] == P_ESC) cand.push_back(i);
    if (cand.size() > 0) begin
      j  = cand[$urandom_range(0, cand.size() - 1)];
      tx = dx[j] + int'($urandom_range(0, 67)) - 2;
      ty = dy[j] + int'($urandom_range(0, 67)) - 2;
      if (tx < 0) tx = 0;
      if (ty < 0) ty = 0;
    end else begin
      tx = int'($urandom_range(0, 1100));
      ty = int'($urandom_range(0, 700));
    end
    mouse_x = 12'(tx);
    mouse_y = 12'(ty);
  endtask

  task automatic drive_random(input bit shooting);
    new_frame   = (cyc % 4 == 0);
    start       = ($urandom_range(0, 19) == 0);
    rnd_dir     = 1'($urandom_range(0, 1));
    rnd_start_x = 10'($urandom_range(0, 1023));
    rnd_v_spd   = 5'($urandom_range(0, 31));
    if (mouse_left || !shooting) mouse_left = 1'b0;
    else mouse_left = ($urandom_range(0, 29) == 0);
    pick_mouse($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0; new_frame = 1'b0; mouse_left = 1'b0;
    #1;
    model_reset();
    compare(1'b1);
    @(posedge clk); #1;
    compare(1'b1);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    new_frame = 0; start = 0; rnd_dir = 0; rnd_start_x = '0; rnd_v_spd = '0;
    mouse_x = '0; mouse_y = '0; mouse_left = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare(1'b1);
    rst = 1'b1;

    // Directed spawn: duck 0 at x=950 heading right with zero speed request,
    // later ducks at x=1000 (clamped); a second start mid-round is ignored.
    for (int k = 0; k < 200; k++) begin
      new_frame   = (cyc % 4 == 0);
      start       = (k == 1) || (k == 40);
      rnd_dir     = 1'b1;
      rnd_start_x = (k < 8) ? 10'd950 : 10'd1000;
      rnd_v_spd   = 5'd0;
      mouse_left  = 1'b0;
      step();
    end

    // Click on a frame cycle at the far corner of duck 0's current box,
    // which lies outside the box after this frame's move.
    start = 1'b0;
    while (cyc % 4 != 0) begin
      new_frame = 1'b0;
      step();
    end
    new_frame  = 1'b1;
    mouse_left = 1'b1;
    mouse_x    = 12'(dx[0] + 63);
    mouse_y    = 12'(dy[0] + 63);
    step();
    check("corner_hit", int'(duck_hit[0]), 1);
    mouse_left = 1'b0;

    for (int seg = 0; seg < 8; seg++) begin
      for (int k = 0; k < 2000; k++) begin
        drive_random(seg % 2 == 1);
        step();
        if (seg == 4 && k == 1000) do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
